riscv_soft_decode_buffer: RTL and testbench
===========================================

Name: riscv_soft_decode_buffer

Overview:
- Fetch-to-execute pipeline stage: registers each fetched instruction and PC, decodes the opcode into the immediate-type select, and flags illegal encodings.
- Execute feeds de_imm_sel straight into the immediate generator.
- Two-entry skid buffer with valid/ready handshakes on both sides, so if_ready depends only on registered state.
- Synchronous flush kills in-flight instructions on a branch or jump redirect.

Parameters:
XPR_LEN, 32, PC width
IMM_I, 3'd0, imm select code: I-type
IMM_S, 3'd1, imm select code: S-type
IMM_B, 3'd2, imm select code: B-type
IMM_U, 3'd3, imm select code: U-type
IMM_J, 3'd4, imm select code: J-type
IMM_NONE, 3'd7, imm select code: no immediate / illegal

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage accepts this cycle
if_inst  in  32  fetched instruction
if_pc  in  XPR_LEN  PC of if_inst
flush  in  1  kill all buffered entries; ignore this cycle's input
de_valid  out  1  head entry valid
de_ready  in  1  execute consumes head
de_inst  out  32  head instruction
de_pc  out  XPR_LEN  head PC
de_imm_sel  out  3  immediate select for head
de_illegal  out  1  head opcode is illegal

Behaviour:
- Storage: two entries, head (H) and skid (S). Each entry holds {valid, inst, pc, imm_sel, illegal}. Decode is done on entry capture, not on the output path.
- Reset (reset_n low, asynchronous):
  - Both valid bits clear.
  - de_valid=0, de_inst=0, de_pc=0, de_imm_sel=IMM_NONE, de_illegal=0.
  - if_ready=1 as soon as reset_n is high.
  - Reset asserted mid-transfer drops both entries with no partial state.
- Outputs: de_* come straight from H. When H is invalid, de_inst, de_pc and de_illegal are don't-care, but de_valid=0.
- if_ready = !S.valid. Registered; no combinational path from de_ready.
- Accept = if_valid & if_ready & !flush. Pop = de_valid & de_ready.
- Occupancy states and transitions (flush=0):
  - EMPTY:
    - accept -> ONE (H loaded).
  - ONE:
    - accept & pop -> ONE (H replaced).
    - accept & !pop -> FULL (S loaded).
    - pop & !accept -> EMPTY.
  - FULL (if_ready=0, no accept):
    - pop -> ONE (S moves to H, S cleared).
- Ordering is strictly FIFO. Latency is 1 cycle from accept to de_valid when the stage was EMPTY.
- flush=1 has priority over everything:
  - Next state EMPTY.
  - Same-cycle accept is suppressed, even if if_valid & if_ready.
  - A same-cycle pop completes normally as far as execute is concerned (execute owns that flush).
- Decode, on opcode inst[6:0], checked only when inst[1:0]==2'b11:
  - 0110111 LUI, 0010111 AUIPC -> IMM_U
  - 1101111 JAL -> IMM_J
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 1110011 SYSTEM, 0001111 MISC-MEM -> IMM_I
  - 0100011 STORE -> IMM_S
  - 1100011 BRANCH -> IMM_B
  - 0110011 OP -> IMM_NONE, illegal=0
  - Any other opcode, or inst[1:0]!=2'b11 -> IMM_NONE, illegal=1
- de_illegal is informational only; the entry still flows through the handshake.
- Inputs are sampled only on accept. Values on if_inst/if_pc while !if_valid have no effect.

Test Plan:
- Reset, then single transfer: reset_n low, then high; if_valid=1, if_inst=32'h00500093 (ADDI), if_pc=0x100 for 1 cycle; de_ready=1 -> next cycle de_valid=1, de_imm_sel=IMM_I, de_pc=0x100, de_illegal=0; following cycle de_valid=0.
- Backpressure fill: de_ready=0; push LUI 32'h123450B7, pc 0x0, then JAL 32'h0080006F, pc 0x4 -> after 2 cycles if_ready=0 and de shows LUI with IMM_U. Raise de_ready -> JAL follows with IMM_J, then if_ready=1.
- Streaming: if_valid=1 and de_ready=1 continuously over 8 instructions covering each opcode class -> one output per cycle, in order, correct imm_sel for each, if_ready never drops.
- Flush in FULL: stage holding 2 entries; flush=1 while if_valid=1 with STORE 32'h00112023 -> next cycle de_valid=0, if_ready=1, and the STORE is never output.
- Illegal: if_inst=32'h0000000B (custom-0), then 32'h00000001 (compressed encoding) -> both emerge with de_illegal=1, de_imm_sel=IMM_NONE. OP 32'h002081B3 -> IMM_NONE, de_illegal=0.
- Async reset mid-operation: FULL with de_ready=0; pulse reset_n low for half a cycle between edges -> de_valid=0 immediately, de_imm_sel=IMM_NONE, if_ready=1 after release.

Source files
------------

// File: rtl/riscv_soft_decode_buffer.sv
// Fetch-to-execute stage: two-entry skid buffer (head + skid) that decodes each
// instruction's immediate type and legality as it is captured.
module riscv_soft_decode_buffer #(
  parameter int         XPR_LEN  = 32,
  parameter logic [2:0] IMM_I    = 3'd0,
  parameter logic [2:0] IMM_S    = 3'd1,
  parameter logic [2:0] IMM_B    = 3'd2,
  parameter logic [2:0] IMM_U    = 3'd3,
  parameter logic [2:0] IMM_J    = 3'd4,
  parameter logic [2:0] IMM_NONE = 3'd7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [31:0]        if_inst,
  input  logic [XPR_LEN-1:0] if_pc,
  input  logic               flush,
  output logic               de_valid,
  input  logic               de_ready,
  output logic [31:0]        de_inst,
  output logic [XPR_LEN-1:0] de_pc,
  output logic [2:0]         de_imm_sel,
  output logic               de_illegal
);

  logic               h_valid_q, h_valid_d, s_valid_q, s_valid_d;
  logic [31:0]        h_inst_q, h_inst_d, s_inst_q, s_inst_d;
  logic [XPR_LEN-1:0] h_pc_q, h_pc_d, s_pc_q, s_pc_d;
  logic [2:0]         h_sel_q, h_sel_d, s_sel_q, s_sel_d;
  logic               h_ill_q, h_ill_d, s_ill_q, s_ill_d;
  logic [2:0]         in_sel;
  logic               in_ill;
  logic               accept, pop;

  // Decode the incoming word once, so the output path is purely registered.
  always_comb begin
    in_sel = IMM_NONE;
    in_ill = 1'b1;
    if (if_inst[1:0] == 2'b11) begin
      in_ill = 1'b0;
      case (if_inst[6:0])
        7'b0110111, 7'b0010111: in_sel = IMM_U;
        7'b1101111:             in_sel = IMM_J;
        7'b1100111, 7'b0000011, 7'b0010011,
        7'b1110011, 7'b0001111: in_sel = IMM_I;
        7'b0100011:             in_sel = IMM_S;
        7'b1100011:             in_sel = IMM_B;
        7'b0110011:             in_sel = IMM_NONE;
        default:                in_ill = 1'b1;
      endcase
    end
  end

  assign accept = if_valid & ~s_valid_q & ~flush;
  assign pop    = h_valid_q & de_ready;

  always_comb begin
    h_valid_d = h_valid_q;
    h_inst_d  = h_inst_q;
    h_pc_d    = h_pc_q;
    h_sel_d   = h_sel_q;
    h_ill_d   = h_ill_q;
    s_valid_d = s_valid_q;
    s_inst_d  = s_inst_q;
    s_pc_d    = s_pc_q;
    s_sel_d   = s_sel_q;
    s_ill_d   = s_ill_q;
    if (flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (pop && s_valid_q) begin
      h_valid_d = 1'b1;
      h_inst_d  = s_inst_q;
      h_pc_d    = s_pc_q;
      h_sel_d   = s_sel_q;
      h_ill_d   = s_ill_q;
      s_valid_d = 1'b0;
    end else if (accept && (pop || !h_valid_q)) begin
      h_valid_d = 1'b1;
      h_inst_d  = if_inst;
      h_pc_d    = if_pc;
      h_sel_d   = in_sel;
      h_ill_d   = in_ill;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_inst_d  = if_inst;
      s_pc_d    = if_pc;
      s_sel_d   = in_sel;
      s_ill_d   = in_ill;
    end else if (pop) begin
      h_valid_d = 1'b0;
    end
    // An empty head always presents "no immediate" to the immediate generator.
    if (!h_valid_d) h_sel_d = IMM_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_valid_q <= 1'b0;
      h_inst_q  <= '0;
      h_pc_q    <= '0;
      h_sel_q   <= IMM_NONE;
      h_ill_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_inst_q  <= '0;
      s_pc_q    <= '0;
      s_sel_q   <= IMM_NONE;
      s_ill_q   <= 1'b0;
    end else begin
      h_valid_q <= h_valid_d;
      h_inst_q  <= h_inst_d;
      h_pc_q    <= h_pc_d;
      h_sel_q   <= h_sel_d;
      h_ill_q   <= h_ill_d;
      s_valid_q <= s_valid_d;
      s_inst_q  <= s_inst_d;
      s_pc_q    <= s_pc_d;
      s_sel_q   <= s_sel_d;
      s_ill_q   <= s_ill_d;
    end
  end

  assign if_ready   = ~s_valid_q;
  assign de_valid   = h_valid_q;
  assign de_inst    = h_inst_q;
  assign de_pc      = h_pc_q;
  assign de_imm_sel = h_sel_q;
  assign de_illegal = h_ill_q;

endmodule

// File: tb/tb_riscv_soft_decode_buffer.sv
// Bench for riscv_soft_decode_buffer: directed scenarios then random traffic,
// all checked against a queue-based model of a 2-deep decoding FIFO.
module tb_riscv_soft_decode_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        de_valid;
  logic        de_ready = 1'b0;
  logic [31:0] de_inst;
  logic [31:0] de_pc;
  logic [2:0]  de_imm_sel;
  logic        de_illegal;

  riscv_soft_decode_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush),
    .de_valid(de_valid), .de_ready(de_ready), .de_inst(de_inst), .de_pc(de_pc),
    .de_imm_sel(de_imm_sel), .de_illegal(de_illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t       model_q[$];
  logic [2:0] sel_map [bit [6:0]];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [6:0] ops [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                             7'h73, 7'h0F, 7'h23, 7'h63, 7'h33};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {illegal, imm_sel} from the opcode table.
  function automatic logic [3:0] ref_decode(input logic [31:0] inst);
    bit [6:0] op;
    op = inst[6:0];
    if (inst[1:0] != 2'b11 || !sel_map.exists(op)) return {1'b1, 3'd7};
    return {1'b0, sel_map[op]};
  endfunction

  task automatic compare_outputs();
    logic [3:0] d;
    check("if_ready", if_ready, model_q.size() < 2);
    check("de_valid", de_valid, model_q.size() > 0);
    if (model_q.size() > 0) begin
      d = ref_decode(model_q[0].inst);
      check("de_inst", de_inst, model_q[0].inst);
      check("de_pc", de_pc, model_q[0].pc);
      check("de_imm_sel", de_imm_sel, d[2:0]);
      check("de_illegal", de_illegal, d[3]);
    end else begin
      check("idle_imm_sel", de_imm_sel, 3'd7);
    end
  endtask

  // One cycle: check outputs, drive inputs, then advance the model on the edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    bit do_pop, do_acc;
    ent_t e;
    @(negedge clk);
    compare_outputs();
    if_valid = v; if_inst = inst; if_pc = pc; de_ready = rdy; flush = fl;
    do_pop = (model_q.size() > 0) && rdy;
    do_acc = v && (model_q.size() < 2) && !fl;
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (fl) model_q.delete();
    else if (do_acc) begin
      e.inst = inst; e.pc = pc;
      model_q.push_back(e);
    end
    $display("cyc v=%0b inst=%08h pc=%08h rdy=%0b fl=%0b pop=%0b acc=%0b occ=%0d",
             v, inst, pc, rdy, fl, do_pop, do_acc, model_q.size());
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 10)]};
  endfunction

  initial begin
    logic [31:0] stream [0:7] = '{32'h123450B7, 32'h00001117, 32'h0080006F, 32'h000080E7,
                                  32'h0000A183, 32'h00112023, 32'h00208463, 32'h002081B3};
    sel_map[7'h37] = 3'd3; sel_map[7'h17] = 3'd3; sel_map[7'h6F] = 3'd4;
    sel_map[7'h67] = 3'd0; sel_map[7'h03] = 3'd0; sel_map[7'h13] = 3'd0;
    sel_map[7'h73] = 3'd0; sel_map[7'h0F] = 3'd0; sel_map[7'h23] = 3'd1;
    sel_map[7'h63] = 3'd2; sel_map[7'h33] = 3'd7;

    #12;
    check("rst_de_valid", de_valid, 1'b0);
    check("rst_de_inst", de_inst, 32'h0);
    check("rst_de_pc", de_pc, 32'h0);
    check("rst_de_imm_sel", de_imm_sel, 3'd7);
    check("rst_de_illegal", de_illegal, 1'b0);
    reset_n = 1'b1;
    #1 check("rst_if_ready", if_ready, 1'b1);

    // Single transfer
    step(1, 32'h00500093, 32'h100, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Backpressure fill and drain
    step(1, 32'h123450B7, 32'h0, 0, 0);
    step(1, 32'h0080006F, 32'h4, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Streaming
    for (int i = 0; i < 8; i++) step(1, stream[i], 32'h200 + 4 * i, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Flush while full, STORE offered in the same cycle
    step(1, 32'h00000013, 32'h300, 0, 0);
    step(1, 32'h00000093, 32'h304, 0, 0);
    step(1, 32'h00112023, 32'h308, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Illegal and OP encodings
    step(1, 32'h0000000B, 32'h400, 1, 0);
    step(1, 32'h00000001, 32'h404, 1, 0);
    step(1, 32'h002081B3, 32'h408, 1, 0);
    step(0, 0, 0, 1, 0);
    // Asynchronous reset while full
    step(1, 32'h00000013, 32'h500, 0, 0);
    step(1, 32'h00000093, 32'h504, 0, 0);
    step(0, 0, 0, 0, 0);
    if_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_de_valid", de_valid, 1'b0);
    check("arst_de_imm_sel", de_imm_sel, 3'd7);
    #1 reset_n = 1'b1;
    model_q.delete();
    #1 check("arst_if_ready", if_ready, 1'b1);
    step(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    step(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
